// File: rtl/cpu_defines_pkg.sv
// Shared pipeline definitions: load types, writeback-select codes and MEM2 FSM states.
package cpu_defines_pkg;

   typedef enum logic [2:0] {
      LT_LB  = 3'd0,
      LT_LBU = 3'd1,
      LT_LH  = 3'd2,
      LT_LHU = 3'd3,
      LT_LW  = 3'd4
   } LoadType_t;

   localparam logic [1:0] WBSEL_PC   = 2'd0;
   localparam logic [1:0] WBSEL_ALU  = 2'd1;
   localparam logic [1:0] WBSEL_OUTB = 2'd2;
   localparam logic [1:0] WBSEL_LOAD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HAVE = 2'd2
   } mem2_state_t;

endpackage

// File: rtl/load_align.sv
// Byte/halfword selection and sign/zero extension of a 32-bit read word.
module load_align
   import cpu_defines_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        addr_i,
   input  LoadType_t         loadtype_i,
   output logic [DATA_W-1:0] result_o
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;

   always_comb begin
      case (addr_i)
         2'd0:    byteVal = rdata_i[7:0];
         2'd1:    byteVal = rdata_i[15:8];
         2'd2:    byteVal = rdata_i[23:16];
         default: byteVal = rdata_i[31:24];
      endcase
      halfVal = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (loadtype_i)
         LT_LB:   result_o = {{(DATA_W-8){byteVal[7]}}, byteVal};
         LT_LBU:  result_o = {{(DATA_W-8){1'b0}}, byteVal};
         LT_LH:   result_o = {{(DATA_W-16){halfVal[15]}}, halfVal};
         LT_LHU:  result_o = {{(DATA_W-16){1'b0}}, halfVal};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem2_stage_lsu.sv
// MEM2 pipeline stage: latches MEM fields, waits for/holds load data, and forms the WB result.
module mem2_stage_lsu
   import cpu_defines_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PC_LINK_OFF = 8,
   parameter int MAX_ORPHAN  = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem2_flush,
   input  logic              mem2_wr,
   input  logic              mem_valid,
   input  logic              mem_isload,
   input  logic [DATA_W-1:0] mem_aluout,
   input  logic [DATA_W-1:0] mem_outb,
   input  logic [31:0]       mem_pc,
   input  logic [1:0]        mem_wbsel,
   input  logic [2:0]        mem_loadtype,
   input  logic [4:0]        mem_dst,
   input  logic              mem_regwr,
   input  logic              dbus_rvalid,
   input  logic [DATA_W-1:0] dbus_rdata,
   output logic [DATA_W-1:0] mem2_result,
   output logic [4:0]        mem2_dst,
   output logic              mem2_regwr,
   output logic              mem2_valid,
   output logic              mem2_stall_req
);

   localparam int OW = $clog2(MAX_ORPHAN + 1);

   logic              valid_q, regwr_q, stall_q;
   logic [4:0]        dst_q;
   logic [DATA_W-1:0] aluout_q, outb_q, hold_q;
   logic [31:0]       pc_q;
   logic [1:0]        wbsel_q;
   LoadType_t         loadtype_q;
   mem2_state_t       state_q, state_d;
   logic [OW-1:0]     orphan_q, orphan_d;

   logic issueLoad, rspDrop, rspCapture, flushWait, orphanOvf, protoErr;
   logic [DATA_W-1:0] alignedData, muxOut;

   assign issueLoad  = mem2_wr & ~mem2_flush & mem_valid & mem_isload;
   assign rspDrop    = dbus_rvalid & (orphan_q != '0);
   assign rspCapture = dbus_rvalid & (orphan_q == '0) & ((state_q == WAIT) | issueLoad);
   // A flushed load only becomes an orphan if its response is not arriving right now.
   assign flushWait  = mem2_flush & (state_q == WAIT) & ~(dbus_rvalid & (orphan_q == '0));
   assign orphanOvf  = flushWait & ~rspDrop & (orphan_q == OW'(MAX_ORPHAN));
   assign protoErr   = dbus_rvalid & (orphan_q == '0) & (state_q != WAIT) & ~issueLoad;

   always_comb begin
      state_d  = state_q;
      orphan_d = orphan_q;
      if (flushWait & ~rspDrop)
         orphan_d = orphanOvf ? orphan_q : orphan_q + OW'(1);
      else if (~flushWait & rspDrop)
         orphan_d = orphan_q - OW'(1);

      if (mem2_flush)
         state_d = IDLE;
      else if (state_q == WAIT) begin
         if (rspCapture)
            state_d = HAVE;
      end else if (mem2_wr)
         state_d = issueLoad ? (rspCapture ? HAVE : WAIT) : IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= IDLE;
         orphan_q <= '0;
         stall_q  <= 1'b0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         orphan_q <= orphan_d;
         stall_q  <= (state_d == WAIT);
         if (rspCapture)
            hold_q <= dbus_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q    <= 1'b0;
         regwr_q    <= 1'b0;
         dst_q      <= '0;
         aluout_q   <= '0;
         outb_q     <= '0;
         pc_q       <= '0;
         wbsel_q    <= '0;
         loadtype_q <= LT_LB;
      end else if (mem2_flush) begin
         valid_q <= 1'b0;
         regwr_q <= 1'b0;
      end else if (mem2_wr) begin
         valid_q    <= mem_valid;
         regwr_q    <= mem_regwr;
         dst_q      <= mem_dst;
         aluout_q   <= mem_aluout;
         outb_q     <= mem_outb;
         pc_q       <= mem_pc;
         wbsel_q    <= mem_wbsel;
         loadtype_q <= LoadType_t'(mem_loadtype);
      end
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         orphanOvfChk: assert (!orphanOvf);
         protoErrChk:  assert (!protoErr);
      end
   end

   load_align #(.DATA_W(DATA_W)) uAlign (
      .rdata_i   (hold_q),
      .addr_i    (aluout_q[1:0]),
      .loadtype_i(loadtype_q),
      .result_o  (alignedData)
   );

   always_comb begin
      case (wbsel_q)
         WBSEL_PC:   muxOut = DATA_W'(pc_q + 32'(PC_LINK_OFF));
         WBSEL_ALU:  muxOut = aluout_q;
         WBSEL_OUTB: muxOut = outb_q;
         default:    muxOut = alignedData;
      endcase
   end

   assign mem2_valid     = valid_q & ~stall_q;
   assign mem2_regwr     = regwr_q & valid_q & ~stall_q;
   assign mem2_stall_req = stall_q;
   assign mem2_dst       = dst_q;
   assign mem2_result    = mem2_valid ? muxOut : '0;

endmodule

// File: tb/tb_mem2_stage_lsu.sv
// Directed-vector bench for mem2_stage_lsu with hand-computed expectations.
module tb_mem2_stage_lsu;
   import cpu_defines_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem2_flush, mem2_wr, mem_valid, mem_isload, mem_regwr, dbus_rvalid;
   logic [31:0] mem_aluout, mem_outb, mem_pc, dbus_rdata;
   logic [1:0]  mem_wbsel;
   logic [2:0]  mem_loadtype;
   logic [4:0]  mem_dst;
   logic [31:0] mem2_result;
   logic [4:0]  mem2_dst;
   logic        mem2_regwr, mem2_valid, mem2_stall_req;

   int vecCount = 0;
   int missCount = 0;

   always #5 clk = ~clk;

   mem2_stage_lsu dut (
      .clk           (clk),
      .resetn        (resetn),
      .mem2_flush    (mem2_flush),
      .mem2_wr       (mem2_wr),
      .mem_valid     (mem_valid),
      .mem_isload    (mem_isload),
      .mem_aluout    (mem_aluout),
      .mem_outb      (mem_outb),
      .mem_pc        (mem_pc),
      .mem_wbsel     (mem_wbsel),
      .mem_loadtype  (mem_loadtype),
      .mem_dst       (mem_dst),
      .mem_regwr     (mem_regwr),
      .dbus_rvalid   (dbus_rvalid),
      .dbus_rdata    (dbus_rdata),
      .mem2_result   (mem2_result),
      .mem2_dst      (mem2_dst),
      .mem2_regwr    (mem2_regwr),
      .mem2_valid    (mem2_valid),
      .mem2_stall_req(mem2_stall_req)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and land 1 time unit past the edge, where outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic isLoad, input logic [31:0] alu, input logic [31:0] outb,
                                input logic [31:0] pc, input logic [1:0] wbsel, input logic [2:0] lt,
                                input logic [4:0] dst, input logic rv, input logic [31:0] rd);
      mem2_wr      = 1'b1;
      mem_valid    = 1'b1;
      mem_regwr    = 1'b1;
      mem_isload   = isLoad;
      mem_aluout   = alu;
      mem_outb     = outb;
      mem_pc       = pc;
      mem_wbsel    = wbsel;
      mem_loadtype = lt;
      mem_dst      = dst;
      dbus_rvalid  = rv;
      dbus_rdata   = rd;
      tick();
      mem2_wr     = 1'b0;
      mem_valid   = 1'b0;
      mem_isload  = 1'b0;
      dbus_rvalid = 1'b0;
   endtask

   task automatic pulseResponse(input logic [31:0] rd);
      dbus_rvalid = 1'b1;
      dbus_rdata  = rd;
      tick();
      dbus_rvalid = 1'b0;
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, ".result"}, mem2_result, 32'h0);
      checkOutput({tag, ".regwr"}, {31'b0, mem2_regwr}, 32'h0);
      checkOutput({tag, ".valid"}, {31'b0, mem2_valid}, 32'h0);
      checkOutput({tag, ".stall"}, {31'b0, mem2_stall_req}, 32'h0);
   endtask

   initial begin
      resetn = 1'b0; mem2_flush = 1'b0; mem2_wr = 1'b0; mem_valid = 1'b0; mem_isload = 1'b0;
      mem_regwr = 1'b0; dbus_rvalid = 1'b0; mem_aluout = '0; mem_outb = '0; mem_pc = '0;
      mem_wbsel = '0; mem_loadtype = '0; mem_dst = '0; dbus_rdata = '0;

      tick();
      tick();
      checkZeroOutputs("reset");
      checkOutput("reset.dst", {27'b0, mem2_dst}, 32'h0);
      resetn = 1'b1;
      tick();

      // ALU, link and OutB writeback paths
      applyStimulus(1'b0, 32'h1234_5678, 32'h0, 32'h0, WBSEL_ALU, LT_LW, 5'd5, 1'b0, 32'h0);
      checkOutput("alu.result", mem2_result, 32'h1234_5678);
      checkOutput("alu.regwr", {31'b0, mem2_regwr}, 32'h1);
      checkOutput("alu.stall", {31'b0, mem2_stall_req}, 32'h0);
      checkOutput("alu.valid", {31'b0, mem2_valid}, 32'h1);
      checkOutput("alu.dst", {27'b0, mem2_dst}, 32'd5);

      applyStimulus(1'b0, 32'h0, 32'h0, 32'hBFC0_0100, WBSEL_PC, LT_LW, 5'd31, 1'b0, 32'h0);
      checkOutput("jal.result", mem2_result, 32'hBFC0_0108);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, WBSEL_PC, LT_LW, 5'd31, 1'b0, 32'h0);
      checkOutput("jalwrap.result", mem2_result, 32'h0000_0004);
      applyStimulus(1'b0, 32'h5, 32'hA5A5_0F0F, 32'h0, WBSEL_OUTB, LT_LW, 5'd2, 1'b0, 32'h0);
      checkOutput("outb.result", mem2_result, 32'hA5A5_0F0F);

      // Load alignment, response in the issuing cycle
      applyStimulus(1'b1, 32'h1000_0003, 32'h0, 32'h0, WBSEL_LOAD, LT_LB, 5'd8, 1'b1, 32'h80FF_0000);
      checkOutput("lb3.result", mem2_result, 32'hFFFF_FF80);
      applyStimulus(1'b1, 32'h1000_0003, 32'h0, 32'h0, WBSEL_LOAD, LT_LBU, 5'd8, 1'b1, 32'h80FF_0000);
      checkOutput("lbu3.result", mem2_result, 32'h0000_0080);
      applyStimulus(1'b1, 32'h1000_0002, 32'h0, 32'h0, WBSEL_LOAD, LT_LB, 5'd8, 1'b1, 32'h80FF_0000);
      checkOutput("lb2.result", mem2_result, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 32'h1000_0001, 32'h0, 32'h0, WBSEL_LOAD, LT_LBU, 5'd8, 1'b1, 32'h1234_5678);
      checkOutput("lbu1.result", mem2_result, 32'h0000_0056);
      applyStimulus(1'b1, 32'h1000_0002, 32'h0, 32'h0, WBSEL_LOAD, LT_LH, 5'd8, 1'b1, 32'h80FF_0000);
      checkOutput("lh2.result", mem2_result, 32'hFFFF_80FF);
      applyStimulus(1'b1, 32'h1000_0002, 32'h0, 32'h0, WBSEL_LOAD, LT_LHU, 5'd8, 1'b1, 32'h80FF_0000);
      checkOutput("lhu2.result", mem2_result, 32'h0000_80FF);
      applyStimulus(1'b1, 32'h1000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LH, 5'd8, 1'b1, 32'h1234_8001);
      checkOutput("lh0.result", mem2_result, 32'hFFFF_8001);
      applyStimulus(1'b1, 32'h1000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd8, 1'b1, 32'h80FF_0000);
      checkOutput("lw.result", mem2_result, 32'h80FF_0000);

      // Late response: three stalled cycles, then data
      applyStimulus(1'b1, 32'h2000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd9, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("late.stall", {31'b0, mem2_stall_req}, 32'h1);
         checkOutput("late.regwr", {31'b0, mem2_regwr}, 32'h0);
         if (i == 2) pulseResponse(32'hDEAD_BEEF);
         else tick();
      end
      checkOutput("late.stallDone", {31'b0, mem2_stall_req}, 32'h0);
      checkOutput("late.result", mem2_result, 32'hDEAD_BEEF);
      checkOutput("late.regwrDone", {31'b0, mem2_regwr}, 32'h1);

      // Flushed load leaves an orphan response that must be dropped
      applyStimulus(1'b1, 32'h3000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd10, 1'b0, 32'h0);
      mem2_flush = 1'b1;
      tick();
      mem2_flush = 1'b0;
      checkOutput("flush.stall", {31'b0, mem2_stall_req}, 32'h0);
      checkOutput("flush.regwr", {31'b0, mem2_regwr}, 32'h0);
      applyStimulus(1'b1, 32'h3000_0004, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd11, 1'b0, 32'h0);
      checkOutput("orphan.stall0", {31'b0, mem2_stall_req}, 32'h1);
      pulseResponse(32'h1111_1111);
      checkOutput("orphan.stall1", {31'b0, mem2_stall_req}, 32'h1);
      pulseResponse(32'h2222_2222);
      checkOutput("orphan.stallDone", {31'b0, mem2_stall_req}, 32'h0);
      checkOutput("orphan.result", mem2_result, 32'h2222_2222);
      checkOutput("orphan.dst", {27'b0, mem2_dst}, 32'd11);

      // Response captured, then MEM2 stalled for four cycles
      applyStimulus(1'b1, 32'h4000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd12, 1'b0, 32'h0);
      pulseResponse(32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         checkOutput("hold.result", mem2_result, 32'hCAFE_F00D);
         tick();
      end

      // Reset mid-WAIT with an orphan outstanding clears everything
      applyStimulus(1'b1, 32'h5000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd13, 1'b0, 32'h0);
      mem2_flush = 1'b1;
      tick();
      mem2_flush = 1'b0;
      applyStimulus(1'b1, 32'h5000_0004, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd14, 1'b0, 32'h0);
      checkOutput("rst.stallBefore", {31'b0, mem2_stall_req}, 32'h1);
      resetn = 1'b0;
      tick();
      checkZeroOutputs("midreset");
      resetn = 1'b1;
      applyStimulus(1'b1, 32'h6000_0000, 32'h0, 32'h0, WBSEL_LOAD, LT_LW, 5'd15, 1'b0, 32'h0);
      pulseResponse(32'hA5A5_5A5A);
      checkOutput("postrst.stall", {31'b0, mem2_stall_req}, 32'h0);
      checkOutput("postrst.result", mem2_result, 32'hA5A5_5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
